hc_read_streamer: RTL and testbench
===================================

// Module: hc_read_streamer
// PURPOSE
//  Converts one stream-read command (base cache-line address, line count) into per-line read requests
//  toward the memory channel. Forwards in-order read responses to the downstream consumer (loopback FIFO).
//  Flow control: memory almost-full plus a consumer credit pool, so the consumer FIFO never overflows.
//  Sits directly upstream of the loopback datapath, behind the hc_buffers_if read side.
// PARAMETERS
//  ADDR_WIDTH       42   cache-line address width
//  DATA_WIDTH       512  cache-line data width
//  LEN_WIDTH        32   width of line count and internal line counters
//  TAG_WIDTH        9    request/response tag width
//  MAX_OUTSTANDING  64   max requests in flight (issued, not yet responded)
//  CREDITS          512  initial consumer credits (= consumer FIFO depth)
// PORTS
//  clk            in   1           single clock, all logic on posedge
//  reset_n        in   1           asynchronous, active-low reset
//  cmd_valid      in   1           command offered
//  cmd_ready      out  1           command accepted when cmd_valid && cmd_ready
//  cmd_base_addr  in   ADDR_WIDTH  first cache-line address
//  cmd_num_lines  in   LEN_WIDTH   lines to read (0 allowed)
//  req_valid      out  1           read request strobe, one line per cycle
//  req_addr       out  ADDR_WIDTH  request address
//  req_tag        out  TAG_WIDTH   request tag
//  req_almost_full in  1           memory channel cannot take a request this cycle
//  rsp_valid      in   1           read response strobe
//  rsp_tag        in   TAG_WIDTH   response tag
//  rsp_data       in   DATA_WIDTH  response data
//  out_valid      out  1           line to consumer (no backpressure; covered by credits)
//  out_data       out  DATA_WIDTH  line data
//  credit_return  in   1           consumer dequeued one line; returns one credit
//  busy           out  1           state != IDLE
//  done           out  1           one-cycle pulse when a command fully completes
//  err            out  1           sticky: tag mismatch or unexpected response
// BEHAVIOUR
//  Reset values: cmd_ready=1, req_valid=0, req_addr=0, req_tag=0, out_valid=0, out_data=0, busy=0, done=0, err=0.
//  Reset: credits=CREDITS, outstanding=0.
//  FSM IDLE -> ISSUE -> DRAIN -> IDLE. cmd_ready=1 only in IDLE.
//  IDLE: on accept, latch base and num_lines; clear issued/received.
//    num_lines==0: done pulses next cycle, FSM stays IDLE. Otherwise go to ISSUE.
//  ISSUE: issue condition is !req_almost_full && credits!=0 && outstanding<MAX_OUTSTANDING.
//    Issue sets req_valid=1 next cycle (registered, 1-cycle latency).
//    req_addr = base+issued, modulo 2^ADDR_WIDTH (wraps silently). req_tag = issued[TAG_WIDTH-1:0].
//    After the last request is issued (issued==num_lines), go to DRAIN.
//  DRAIN: wait for received==num_lines, then pulse done for one cycle and return to IDLE.
//    Final response may land in the ISSUE->DRAIN transition cycle; done must not be lost.
//  Responses are in order. Each rsp_valid must carry tag==received[TAG_WIDTH-1:0].
//    Mismatch: err set sticky; data still forwarded.
//  rsp_valid in IDLE is dropped, sets err, and does not touch counters.
//  out_valid/out_data are registered copies of rsp_valid/rsp_data (1-cycle latency).
//  credits: -1 on issue, +1 on credit_return; both in one cycle = no change.
//    Saturate at CREDITS; a credit_return beyond CREDITS sets err.
//  outstanding: +1 on issue, -1 on rsp_valid; simultaneous = no change.
//  reset_n low mid-command: abort at once, all state to reset values.
//    In-flight responses after reset then arrive in IDLE and set err (documented, expected).
// CONFIGURATION
//  HC_READ_STREAMER_STATS_EN defined: adds outputs stat_req_cnt[31:0] and stat_stall_cnt[31:0].
//    stat_req_cnt counts issued requests; stat_stall_cnt counts ISSUE cycles with no issue.
//    Both reset to 0, wrap at 2^32, cleared on command accept.
//  Undefined: the two ports and their counters do not exist.
// STRUCTURE
//  hc_pkg: t_cl_addr, t_cl_data, t_tag typedefs; t_rs_state enum {IDLE, ISSUE, DRAIN}.
//  Sub-module hc_updown_counter (WIDTH, INIT; inc, dec, value): one for credits, one for outstanding.
// TESTING
//  1 cmd base=0x100 lines=4, no stalls -> req_addr 0x100..0x103, tags 0..3, 4 out_valid, 1 done, err=0.
//  2 lines=0 -> no req_valid; done pulses 1 cycle after accept; cmd_ready stays 1.
//  3 CREDITS=8, lines=16, no credit_return -> exactly 8 requests; stall; each credit_return issues one more.
//  4 req_almost_full high 10 cycles mid-ISSUE -> no req_valid during it; issue resumes; addresses contiguous.
//  5 base=2^42-2, lines=4 -> req_addr 3FF..FE, 3FF..FF, 0, 1.
//  6 rsp_tag=5 when 3 expected -> err=1 and stays 1; also reset_n low mid-DRAIN -> outputs at reset values.

Source files
------------

// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared widths, cache-line typedefs and read-streamer FSM states
package hc_pkg;

  localparam int HC_ADDR_WIDTH = 42;
  localparam int HC_DATA_WIDTH = 512;
  localparam int HC_LEN_WIDTH  = 32;
  localparam int HC_TAG_WIDTH  = 9;

  typedef logic [HC_ADDR_WIDTH-1:0] t_cl_addr;
  typedef logic [HC_DATA_WIDTH-1:0] t_cl_data;
  typedef logic [HC_TAG_WIDTH-1:0]  t_tag;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } t_rs_state;

endpackage

// File: rtl/hc_updown_counter.sv
// rtl/hc_updown_counter.sv - up/down counter; simultaneous inc and dec leave the value unchanged
module hc_updown_counter #(
  parameter int WIDTH = 8,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= WIDTH'(INIT);
    end else if (inc && !dec) begin
      r_value <= r_value + ONE;
    end else if (dec && !inc) begin
      r_value <= r_value - ONE;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/hc_read_streamer.sv
// rtl/hc_read_streamer.sv - turns one (base, num_lines) command into per-line reads and forwards responses
// Optional HC_READ_STREAMER_STATS_EN adds issued-request and issue-stall counters.
module hc_read_streamer
  import hc_pkg::*;
#(
  parameter int ADDR_WIDTH      = HC_ADDR_WIDTH,
  parameter int DATA_WIDTH      = HC_DATA_WIDTH,
  parameter int LEN_WIDTH       = HC_LEN_WIDTH,
  parameter int TAG_WIDTH       = HC_TAG_WIDTH,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CREDITS         = 512
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_num_lines,
  output logic                  req_valid,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  req_almost_full,
  input  logic                  rsp_valid,
  input  logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  credit_return,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef HC_READ_STREAMER_STATS_EN
  ,
  output logic [31:0]           stat_req_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);

  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [LEN_WIDTH-1:0] ONE_LEN = LEN_WIDTH'(1);

  t_rs_state             r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LEN_WIDTH-1:0]  r_num_lines;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_received;
  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [TAG_WIDTH-1:0]  r_req_tag;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_done;
  logic                  r_err;

  logic [CRD_W-1:0]      w_credits;
  logic [OUT_W-1:0]      w_outstanding;
  logic                  w_issue;
  logic                  w_rsp_acc;
  logic                  w_cred_full;
  logic                  w_credit_inc;
  logic                  w_credit_over;

  assign w_cred_full   = (w_credits == CRD_W'(CREDITS));
  assign w_issue       = (r_state == ISSUE) && !req_almost_full && (w_credits != '0) &&
                         (w_outstanding < OUT_W'(MAX_OUTSTANDING));
  // Responses count only while a command is active and still owed lines.
  assign w_rsp_acc     = rsp_valid && (r_state != IDLE) && (r_received != r_num_lines);
  assign w_credit_over = credit_return && w_cred_full && !w_issue;
  assign w_credit_inc  = credit_return && !w_credit_over;

  hc_updown_counter #(.WIDTH(CRD_W), .INIT(CREDITS)) u_credits (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_credit_inc),
    .dec     (w_issue),
    .value   (w_credits)
  );

  hc_updown_counter #(.WIDTH(OUT_W), .INIT(0)) u_outstanding (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_issue),
    .dec     (w_rsp_acc),
    .value   (w_outstanding)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_num_lines <= '0;
      r_issued    <= '0;
      r_received  <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_tag   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_req_valid <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= w_rsp_acc;
      if (w_rsp_acc) begin
        r_out_data <= rsp_data;
        r_received <= r_received + ONE_LEN;
        if (rsp_tag != r_received[TAG_WIDTH-1:0]) begin
          r_err <= 1'b1;
        end
      end else if (rsp_valid) begin
        r_err <= 1'b1;
      end
      if (w_credit_over) begin
        r_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_base      <= cmd_base_addr;
            r_num_lines <= cmd_num_lines;
            r_issued    <= '0;
            r_received  <= '0;
            if (cmd_num_lines == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= r_base + ADDR_WIDTH'(r_issued);
            r_req_tag   <= r_issued[TAG_WIDTH-1:0];
            r_issued    <= r_issued + ONE_LEN;
            if (r_issued + ONE_LEN == r_num_lines) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // received already includes any response that landed on the ISSUE->DRAIN edge
          if (r_received == r_num_lines) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef HC_READ_STREAMER_STATS_EN
  logic [31:0] r_stat_req;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_req   <= '0;
      r_stat_stall <= '0;
    end else if ((r_state == IDLE) && cmd_valid) begin
      r_stat_req   <= '0;
      r_stat_stall <= '0;
    end else if (w_issue) begin
      r_stat_req   <= r_stat_req + 32'd1;
    end else if (r_state == ISSUE) begin
      r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_req_cnt   = r_stat_req;
  assign stat_stall_cnt = r_stat_stall;
`endif

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign req_valid = r_req_valid;
  assign req_addr  = r_req_addr;
  assign req_tag   = r_req_tag;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_hc_read_streamer.sv
// tb/tb_hc_read_streamer.sv - scoreboard bench for hc_read_streamer with a small memory and consumer model
module tb_hc_read_streamer;

  localparam int AW   = 42;
  localparam int DW   = 512;
  localparam int LW   = 32;
  localparam int TW   = 9;
  localparam int CRED = 8;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [AW-1:0] addr;
  } t_req;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr;
  logic [LW-1:0] cmd_num_lines;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic [TW-1:0] req_tag;
  logic          req_almost_full;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tag;
  logic [DW-1:0] rsp_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          credit_return;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  t_req          exp_req[$];
  t_req          mem_q[$];
  logic [DW-1:0] exp_out[$];

  int req_seen = 0, out_seen = 0, done_cnt = 0, held = 0;
  int rsp_idx = 0, corrupt_idx = -1, man_credits = 0;
  bit rsp_en = 1'b0, auto_credit = 1'b0;

  hc_read_streamer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
    .MAX_OUTSTANDING(64), .CREDITS(CRED)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_base_addr   (cmd_base_addr),
    .cmd_num_lines   (cmd_num_lines),
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_tag         (req_tag),
    .req_almost_full (req_almost_full),
    .rsp_valid       (rsp_valid),
    .rsp_tag         (rsp_tag),
    .rsp_data        (rsp_data),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .credit_return   (credit_return),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 64; i++) begin
      d[i*64 +: 64] = {22'(i), a} ^ 64'hA5A5_3C3C_0F0F_9696;
    end
    return d;
  endfunction

  // Monitor / scoreboard
  initial begin
    t_req e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (req_valid) begin
          req_seen++;
          if (exp_req.size() == 0) begin
            check("req_unexpected", DW'(req_valid), DW'(0));
          end else begin
            e = exp_req.pop_front();
            check("req_addr", DW'(req_addr), DW'(e.addr));
            check("req_tag", DW'(req_tag), DW'(e.tag));
          end
          mem_q.push_back('{tag: req_tag, addr: req_addr});
        end
        if (out_valid) begin
          out_seen++;
          held++;
          if (exp_out.size() == 0) check("out_unexpected", DW'(out_valid), DW'(0));
          else check("out_data", out_data, exp_out.pop_front());
        end
        if (done) done_cnt++;
      end
    end
  end

  // Memory responder: one in-order response per cycle
  initial begin
    t_req r;
    forever begin
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      if (reset_n && rsp_en && mem_q.size() > 0) begin
        r = mem_q.pop_front();
        rsp_valid = 1'b1;
        rsp_tag   = (rsp_idx == corrupt_idx) ? TW'(5) : r.tag;
        rsp_data  = mk_data(r.addr);
        rsp_idx++;
      end
    end
  end

  // Consumer: returns one credit per dequeued line
  initial begin
    forever begin
      @(posedge clk);
      #1;
      credit_return = 1'b0;
      if (reset_n && held > 0 && (auto_credit || man_credits > 0)) begin
        credit_return = 1'b1;
        held--;
        if (!auto_credit) man_credits--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cmd_ready"}, DW'(cmd_ready), DW'(1));
    check({pfx, "_req_valid"}, DW'(req_valid), DW'(0));
    check({pfx, "_req_addr"},  DW'(req_addr),  DW'(0));
    check({pfx, "_req_tag"},   DW'(req_tag),   DW'(0));
    check({pfx, "_out_valid"}, DW'(out_valid), DW'(0));
    check({pfx, "_out_data"},  out_data,       DW'(0));
    check({pfx, "_busy"},      DW'(busy),      DW'(0));
    check({pfx, "_done"},      DW'(done),      DW'(0));
    check({pfx, "_err"},       DW'(err),       DW'(0));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [AW-1:0] base, input logic [LW-1:0] n);
    int w;
    logic [AW-1:0] a;
    w = 0;
    while (!cmd_ready && w < 100) begin
      tick(1);
      w++;
    end
    check("cmd_ready_wait", DW'(cmd_ready), DW'(1));
    for (int unsigned i = 0; i < n; i++) begin
      a = base + AW'(i);
      exp_req.push_back('{tag: TW'(i), addr: a});
      exp_out.push_back(mk_data(a));
    end
    rsp_idx  = 0;
    req_seen = 0;
    out_seen = 0;
    done_cnt = 0;
    cmd_valid     = 1'b1;
    cmd_base_addr = base;
    cmd_num_lines = n;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int c;
    c = 0;
    while (done_cnt == 0 && c < max) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done_seen"}, DW'(done_cnt != 0), DW'(1));
    tick(6);
  endtask

  task automatic wait_reqs(input int target, input int max);
    int c;
    c = 0;
    while (req_seen < target && c < max) begin
      @(negedge clk);
      c++;
    end
    check("req_wait", DW'(req_seen >= target), DW'(1));
  endtask

  initial begin
    int viol;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_base_addr = '0;
    cmd_num_lines = '0;
    req_almost_full = 1'b0;
    rsp_valid = 1'b0;
    rsp_tag = '0;
    rsp_data = '0;
    credit_return = 1'b0;
    tick(3);
    check_reset_vals("por");
    reset_n = 1'b1;
    tick(2);

    // 1: basic 4-line read
    rsp_en = 1'b1;
    auto_credit = 1'b1;
    send_cmd(42'h100, 4);
    wait_done("t1", 200);
    check("t1_req_cnt", DW'(req_seen), DW'(4));
    check("t1_out_cnt", DW'(out_seen), DW'(4));
    check("t1_done_cnt", DW'(done_cnt), DW'(1));
    check("t1_err", DW'(err), DW'(0));
    check("t1_busy", DW'(busy), DW'(0));

    // 2: zero-length command
    send_cmd(42'h200, 0);
    check("t2_done", DW'(done), DW'(1));
    check("t2_cmd_ready", DW'(cmd_ready), DW'(1));
    tick(1);
    check("t2_done_pulse", DW'(done), DW'(0));
    tick(5);
    check("t2_req_cnt", DW'(req_seen), DW'(0));
    check("t2_done_cnt", DW'(done_cnt), DW'(1));
    check("t2_busy", DW'(busy), DW'(0));

    // 3: credit exhaustion
    tick(10);
    auto_credit = 1'b0;
    send_cmd(42'h2000, 16);
    tick(40);
    check("t3_req_at_stall", DW'(req_seen), DW'(CRED));
    check("t3_busy", DW'(busy), DW'(1));
    man_credits = 1;
    tick(10);
    check("t3_req_after_one", DW'(req_seen), DW'(CRED + 1));
    auto_credit = 1'b1;
    wait_done("t3", 400);
    check("t3_req_cnt", DW'(req_seen), DW'(16));
    check("t3_out_cnt", DW'(out_seen), DW'(16));
    check("t3_err", DW'(err), DW'(0));

    // 4: almost-full window mid-ISSUE
    send_cmd(42'h3000, 20);
    wait_reqs(3, 100);
    tick(1);
    req_almost_full = 1'b1;
    viol = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (req_valid) viol++;
    end
    req_almost_full = 1'b0;
    check("t4_af_quiet", DW'(viol), DW'(0));
    wait_done("t4", 400);
    check("t4_req_cnt", DW'(req_seen), DW'(20));
    check("t4_out_cnt", DW'(out_seen), DW'(20));

    // 5: address wrap at 2^42
    send_cmd(42'h3FF_FFFF_FFFE, 4);
    wait_done("t5", 200);
    check("t5_req_cnt", DW'(req_seen), DW'(4));
    check("t5_err", DW'(err), DW'(0));

    // 6: tag mismatch, then reset mid-DRAIN, then stray response in IDLE
    corrupt_idx = 3;
    send_cmd(42'h500, 4);
    wait_done("t6", 200);
    check("t6_err", DW'(err), DW'(1));
    check("t6_out_cnt", DW'(out_seen), DW'(4));
    tick(10);
    check("t6_err_sticky", DW'(err), DW'(1));
    corrupt_idx = -1;

    rsp_en = 1'b0;
    send_cmd(42'h600, 4);
    wait_reqs(4, 100);
    tick(1);
    check("t6_drain_busy", DW'(busy), DW'(1));
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid");
    exp_req.delete();
    exp_out.delete();
    mem_q.delete();
    held = 0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    mem_q.push_back('{tag: TW'(0), addr: AW'(0)});
    rsp_en = 1'b1;
    tick(4);
    check("t6_idle_rsp_err", DW'(err), DW'(1));
    check("t6_idle_busy", DW'(busy), DW'(0));
    check("t6_idle_out", DW'(out_valid), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
